mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store front end placed directly upstream of the word-only data memory. Accepts byte, halfword and word load/store requests from the CPU memory stage, presents word-aligned accesses to the memory, and performs sign/zero extension on loads. Sub-word stores use read-modify-write. Returns one response per request over a valid/ready handshake.

## Interface
- `ADDR_W`, default 32: request and memory address width.
- `DATA_W`, default 32: data width; fixed at 32 (four byte lanes).
- `clk` in 1: sole clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-low; sampled on the rising edge of `clk`.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 treated as word.
- `req_unsigned` in 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in 32: store data, right-justified.
- `resp_valid` out 1: one-cycle response pulse.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_err` out 1: misaligned request; valid with `resp_valid`.
- `mem_rd` out 1, `mem_wr` out 1: memory strobes.
- `mem_addr` out ADDR_W: `{req_addr[ADDR_W-1:2], 2'b00}`.
- `mem_wdata` out 32: word to write.
- `mem_rdata` in 32: combinational memory read data, valid in the same cycle as `mem_rd`.

## Operation
- FSM states: IDLE, RD, WR, DONE.
- IDLE: `req_ready`=1. Accept on `req_valid && req_ready`; latch we/size/unsigned/addr/wdata.
  - Load → RD. Word store → WR. Sub-word store → RD (RMW). Misaligned (see Configuration) → DONE with error.
- RD: `mem_rd`=1; `mem_rdata` latched into the read buffer at the edge. Load → DONE. RMW → WR.
- WR: `mem_wr`=1. `mem_wdata` = `req_wdata` for a word store. For a sub-word store, the read buffer with the addressed lane(s) replaced. → DONE.
- DONE: `resp_valid`=1, `req_ready`=0. → IDLE.
- Lanes are little-endian. Byte k (addr[1:0]=k) occupies bits [8k+7:8k]. Half h (addr[1]=h) occupies bits [16h+15:16h].
- Load extraction: the selected lane is shifted to bit 0, then extended to 32 bits per `req_unsigned`. Word loads pass through unchanged.
- Store data uses only its low 8 or 16 bits for sub-word sizes.
- `resp_rdata` is registered. It updates on entry to DONE and holds until the next DONE.
- Reset (`reset`=0 at an edge): state → IDLE; `resp_valid`=0, `resp_err`=0, `resp_rdata`=0, read buffer=0.
- While `reset`=0, `mem_rd` and `mem_wr` are forced to 0 combinationally, so a reset mid-RMW issues no write.

## Timing
- Accept at edge N. Then `resp_valid` is high in:
  - load: cycle N+2;
  - word store: cycle N+2;
  - sub-word store: cycle N+3;
  - error: cycle N+1.
- Memory strobes last exactly one cycle per state; at most one `mem_wr` per request.
- `req_ready` is high only in IDLE. Maximum throughput is one request per 3 cycles (4 for RMW).
- `req_*` inputs are ignored outside IDLE. Captured values are used throughout the request.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined: misalignment is detected at accept.
  - Misaligned means half with addr[0]=1, or word/11 with addr[1:0]≠0.
  - On misalignment: no memory strobe, DONE with `resp_err`=1, `resp_rdata`=0.
- Undefined: no check.
  - Halfword uses addr[1] only; word ignores addr[1:0].
  - `resp_err` is tied to 0.

## Structure
- Package `mem_access_pkg`: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), FSM state enum, lane width constants.
- Sub-module `mem_lane_merge`, purely combinational, with two functions:
  - extract + extend: read word, addr[1:0], size, unsigned → load data;
  - merge: old word, wdata, addr[1:0], size → write word.

## Test plan
- Reset: hold `reset`=0 for 2 cycles → `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, no strobes.
- Word store 0xDEADBEEF @0x10, then word load @0x10 → one `mem_wr` at mem_addr 0x10; load `resp_rdata`=0xDEADBEEF two cycles after accept.
- Memory 0x80FF7F01 @0x20:
  - lb @0x23 → 0xFFFFFF80; lbu @0x23 → 0x00000080;
  - lh @0x22 → 0xFFFF80FF; lhu @0x20 → 0x00007F01.
- sb 0xAA @0x21 over 0x11223344 → RD then WR, `mem_wdata`=0x1122AA44, `resp_valid` at N+3.
- Reset pulsed during RD of an RMW → no `mem_wr`, FSM in IDLE, memory word unchanged.
- With `MEM_ALIGN_CHECK_EN`: lw @0x22 → `resp_err`=1 at N+1, no strobes. Without the macro: lw @0x22 reads the word at 0x20, `resp_err`=0.

Source files
------------

// File: rtl/mem_access_pkg.sv
`default_nettype none
// mem_access_pkg -- size encodings, FSM state codes and lane widths for mem_access_unit (rev 1.0)
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int LANE_W = 8;
  localparam int HALF_W = 16;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RD   = 2'd1;
  localparam state_t ST_WR   = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  // Encoding 2'b11 behaves exactly like a word access.
  function automatic logic is_word(input logic [1:0] sz);
    return (sz == SZ_WORD) || (sz == 2'b11);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_merge.sv
`default_nettype none
// mem_lane_merge -- little-endian lane extract/extend for loads and lane merge for stores (rev 1.0)
module mem_lane_merge
  import mem_access_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [LANE_W-1:0] byte_sel;
  logic [HALF_W-1:0] half_sel;

  always_comb begin
    byte_sel  = rd_word[{addr_lo, 3'b000} +: LANE_W];
    half_sel  = rd_word[{addr_lo[1], 4'b0000} +: HALF_W];
    load_data = rd_word;
    if (size == SZ_BYTE) begin
      load_data = {{(32-LANE_W){byte_sel[LANE_W-1] & ~is_unsigned}}, byte_sel};
    end else if (size == SZ_HALF) begin
      load_data = {{(32-HALF_W){half_sel[HALF_W-1] & ~is_unsigned}}, half_sel};
    end
  end

  always_comb begin
    merged_word = wdata;
    if (size == SZ_BYTE) begin
      merged_word = old_word;
      merged_word[{addr_lo, 3'b000} +: LANE_W] = wdata[LANE_W-1:0];
    end else if (size == SZ_HALF) begin
      merged_word = old_word;
      merged_word[{addr_lo[1], 4'b0000} +: HALF_W] = wdata[HALF_W-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// mem_access_unit -- byte/half/word load-store front end over a word-only memory (rev 1.0)
// Optional: define MEM_ALIGN_CHECK_EN to reject misaligned half/word requests with resp_err.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rbuf_q, rbuf_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              misaligned;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merged_word;

`ifdef MEM_ALIGN_CHECK_EN
  always_comb begin
    misaligned = 1'b0;
    if (req_size == SZ_HALF) begin
      misaligned = req_addr[0];
    end else if (is_word(req_size)) begin
      misaligned = |req_addr[1:0];
    end
  end
`else
  assign misaligned = 1'b0;
`endif

  mem_lane_merge u_lane_merge (
    .rd_word     (mem_rdata),
    .old_word    (rbuf_q),
    .wdata       (wdata_q),
    .addr_lo     (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rbuf_d  = rbuf_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (misaligned) begin
            state_d = ST_DONE;
            rdata_d = '0;
            err_d   = 1'b1;
          end else if (req_we && is_word(req_size)) begin
            state_d = ST_WR;
          end else begin
            // Loads and sub-word stores (read half of the RMW) both read first.
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        rbuf_d = mem_rdata;
        if (we_q) begin
          state_d = ST_WR;
        end else begin
          state_d = ST_DONE;
          rdata_d = load_data;
          err_d   = 1'b0;
        end
      end
      ST_WR: begin
        state_d = ST_DONE;
        rdata_d = '0;
        err_d   = 1'b0;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rbuf_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rbuf_q  <= rbuf_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_DONE);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  // Strobes are gated by reset so an interrupted RMW never writes.
  assign mem_rd     = reset && (state_q == ST_RD);
  assign mem_wr     = reset && (state_q == ST_WR);
  assign mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_wdata  = merged_word;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// tb_mem_access_unit -- scoreboard bench with a word-array reference model of the load/store rules.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Word memory seen by the DUT (64 words, byte addresses 0x00..0xFF).
  logic [31:0] mem [0:63];
  logic        mem_clr = 1'b1;
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else if (mem_wr) begin
      mem[mem_addr[7:2]] <= mem_wdata;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] rdata; logic err; int cyc; } rsp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  rsp_t rq[$];
  wr_t  wq[$];
  rsp_t mr;
  wr_t  mw;

  logic [31:0] ref_mem [0:63];
  int n_cmp = 0, n_bad = 0, rd_cnt = 0, exp_rd = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference rules in plain arithmetic.
  function automatic logic [31:0] model_load(input logic [31:0] w, input int a, input int sz, input bit u);
    logic [31:0] v;
    if (sz == 0) begin
      v = (w >> (8 * (a % 4))) & 32'hFF;
      if (!u && v >= 32'd128) v = v + 32'hFFFF_FF00;
    end else if (sz == 1) begin
      v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      if (!u && v >= 32'd32768) v = v + 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] w, input int a, input int sz, input logic [31:0] wd);
    logic [31:0] mask;
    int sh;
    if (sz == 0) begin
      sh = 8 * (a % 4);
      mask = 32'hFF << sh;
      return (w & ~mask) | ((wd & 32'hFF) << sh);
    end else if (sz == 1) begin
      sh = 16 * ((a / 2) % 2);
      mask = 32'hFFFF << sh;
      return (w & ~mask) | ((wd & 32'hFFFF) << sh);
    end
    return wd;
  endfunction

  function automatic bit model_misaligned(input int a, input int sz);
`ifdef MEM_ALIGN_CHECK_EN
    return (sz == 1 && (a % 2) != 0) || (sz >= 2 && (a % 4) != 0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic wait_ready();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 50);
    if (!req_ready) check("ready_timeout", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic issue(input bit we, input int sz, input bit u, input int a, input logic [31:0] wd);
    rsp_t r;
    wr_t  w;
    int   lat;
    logic [31:0] old;
    wait_ready();
    req_valid = 1'b1; req_we = we; req_size = sz[1:0];
    req_unsigned = u; req_addr = a; req_wdata = wd;
    old = ref_mem[a / 4];
    r.rdata = '0;
    r.err = 1'b0;
    if (model_misaligned(a, sz)) begin
      lat = 1;
      r.err = 1'b1;
    end else if (!we) begin
      lat = 2;
      r.rdata = model_load(old, a, sz, u);
      exp_rd++;
    end else begin
      lat = (sz >= 2) ? 2 : 3;
      if (sz < 2) exp_rd++;
      ref_mem[a / 4] = model_store(old, a, sz, wd);
      w.addr = (a / 4) * 4;
      w.data = ref_mem[a / 4];
      wq.push_back(w);
    end
    r.cyc = cyc + lat;
    rq.push_back(r);
    @(posedge clk);
    #1;
    // Scramble request fields while busy; the DUT must use its captured copy.
    req_valid = 1'b0;
    req_we = $urandom_range(1, 0);
    req_size = 2'($urandom_range(3, 0));
    req_addr = $urandom;
    req_wdata = $urandom;
  endtask

  // Monitor: strobes and responses against the scoreboard queues.
  always @(negedge clk) begin
    if (mem_rd) rd_cnt++;
    if (mem_rd && mem_wr) check("strobe_overlap", 32'd1, 32'd0);
    if (mem_wr) begin
      if (wq.size() == 0) begin
        check("unexpected_write", mem_addr, 32'hFFFF_FFFF);
      end else begin
        mw = wq.pop_front();
        check("wr_addr", mem_addr, mw.addr);
        check("wr_data", mem_wdata, mw.data);
      end
    end
    if (resp_valid) begin
      if (rq.size() == 0) begin
        check("unexpected_resp", resp_rdata, 32'hFFFF_FFFF);
      end else begin
        mr = rq.pop_front();
        check("resp_rdata", resp_rdata, mr.rdata);
        check("resp_err", {31'd0, resp_err}, {31'd0, mr.err});
        check("resp_cycle", cyc, mr.cyc);
      end
    end
  end

  initial begin
    int t;
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_strobes", {30'd0, mem_rd, mem_wr}, 32'd0);
    mem_clr = 1'b0;
    reset = 1'b1;

    issue(1, 2, 0, 'h10, 32'hDEAD_BEEF);
    issue(0, 2, 0, 'h10, 32'h0);
    issue(1, 2, 0, 'h20, 32'h80FF_7F01);
    issue(0, 0, 0, 'h23, 32'h0);
    issue(0, 0, 1, 'h23, 32'h0);
    issue(0, 1, 0, 'h22, 32'h0);
    issue(0, 1, 1, 'h20, 32'h0);
    issue(1, 2, 0, 'h20, 32'h1122_3344);
    issue(1, 0, 0, 'h21, 32'hFFFF_FFAA);
    issue(0, 2, 0, 'h20, 32'h0);

    // Reset during the read phase of a byte store must abort without writing.
    wait_ready();
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 'h21; req_wdata = 32'h55;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("rmw_rd_phase", {31'd0, mem_rd}, 32'd1);
    reset = 1'b0;
    #1;
    check("rst_gates_strobes", {30'd0, mem_rd, mem_wr}, 32'd0);
    @(posedge clk);
    #1;
    check("midrst_ready", {31'd0, req_ready}, 32'd1);
    check("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("midrst_rdata", resp_rdata, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_mem_word", mem[8], ref_mem[8]);

    issue(0, 2, 0, 'h22, 32'h0);
    issue(0, 1, 0, 'h21, 32'h0);
    issue(1, 1, 0, 'h13, 32'hCAFE);
    issue(1, 3, 0, 'h11, 32'h0BAD_F00D);
    issue(0, 3, 1, 'h10, 32'h0);

    for (int k = 0; k < 200; k++) begin
      issue($urandom_range(1, 0), $urandom_range(3, 0), $urandom_range(1, 0),
            $urandom_range(255, 0), $urandom);
    end

    t = 0;
    while ((rq.size() != 0 || wq.size() != 0) && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("resp_queue_drained", rq.size(), 32'd0);
    check("write_queue_drained", wq.size(), 32'd0);
    check("read_strobe_count", rd_cnt, exp_rd);
    for (int i = 0; i < 64; i++) check("final_mem_word", mem[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
